// File: rtl/slurm16_hazard_pkg.sv
// Shared hazard-tracking types and register constants for the SLURM16 pipeline.
// Stage entries carry the widest supported register index so the type is parameter-independent.
package slurm16_hazard_pkg;

  localparam int MAX_REGISTER_BITS = 8;
  localparam int R0                = 0;
  localparam int LINK_REGISTER     = 15;

  typedef struct packed {
    logic                         valid;
    logic [MAX_REGISTER_BITS-1:0] dest;
    logic                         mod_flags;
    logic                         is_load;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/slurm16_reg_scoreboard.sv
// One pending bit per register for multi-cycle loads still outstanding in memory.
// A set and a clear of the same register in one cycle leaves the bit set; R0 never pends.
module slurm16_reg_scoreboard
  import slurm16_hazard_pkg::*;
#(
  parameter int REGISTER_BITS = 7,
  parameter int NUM_REGS      = 2**REGISTER_BITS
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     set,
  input  logic [REGISTER_BITS-1:0] set_reg,
  input  logic                     clr,
  input  logic [REGISTER_BITS-1:0] clr_reg,
  input  logic [REGISTER_BITS-1:0] look_a,
  input  logic [REGISTER_BITS-1:0] look_b,
  input  logic [REGISTER_BITS-1:0] look_c,
  output logic                     hit_a,
  output logic                     hit_b,
  output logic                     hit_c
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_next;

  // Set is applied after clear so it wins on a same-register collision.
  always_comb begin
    sb_next = sb;
    if (clr) sb_next[clr_reg] = 1'b0;
    if (set) sb_next[set_reg] = 1'b1;
    sb_next[R0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) sb <= '0;
    else       sb <= sb_next;
  end

  assign hit_a = sb[look_a];
  assign hit_b = sb[look_b];
  assign hit_c = sb[look_c];

endmodule

// File: rtl/slurm16_cpu_scoreboard.sv
// Hazard and stall unit: tracks in-flight writers over DEPTH stages plus outstanding loads,
// and flags dependencies of the p0 issue slot against both.
module slurm16_cpu_scoreboard
  import slurm16_hazard_pkg::*;
#(
  parameter int REGISTER_BITS = 7,
  parameter int DEPTH         = 3,
  parameter int NUM_REGS      = 2**REGISTER_BITS
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     p0_valid,
  input  logic [REGISTER_BITS-1:0] p0_regA,
  input  logic [REGISTER_BITS-1:0] p0_regB,
  input  logic [REGISTER_BITS-1:0] p0_dest,
  input  logic                     p0_mod_flags,
  input  logic                     p0_uses_flags,
  input  logic                     p0_is_load,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     ld_done,
  input  logic [REGISTER_BITS-1:0] ld_done_reg,
  output logic [DEPTH-1:0]         hazard,
  output logic                     hazard_sb,
  output logic                     stall
);

  stage_t [DEPTH-1:0] stages;
  stage_t             entry;
  logic               advance;
  logic               sb_set;
  logic               hit_a, hit_b, hit_d;

  logic [MAX_REGISTER_BITS-1:0] reg_a_ext, reg_b_ext;
  logic                         reg_a_live, reg_b_live;

  assign reg_a_ext  = MAX_REGISTER_BITS'(p0_regA);
  assign reg_b_ext  = MAX_REGISTER_BITS'(p0_regB);
  assign reg_a_live = (p0_regA != REGISTER_BITS'(R0));
  assign reg_b_live = (p0_regB != REGISTER_BITS'(R0));
  assign advance    = ~hold & ~flush;

  // A stalled p0 enters stage 1 as a bubble so it is not tracked twice.
  always_comb begin
    entry = STAGE_EMPTY;
    if (p0_valid && !stall) begin
      entry.valid     = 1'b1;
      entry.dest      = MAX_REGISTER_BITS'(p0_dest);
      entry.mod_flags = p0_mod_flags;
      entry.is_load   = p0_is_load;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      stages <= '0;
    end else if (flush) begin
      stages <= '0;
    end else if (!hold) begin
      for (int i = DEPTH - 1; i > 0; i--) stages[i] <= stages[i-1];
      stages[0] <= entry;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_cmp
      assign hazard[g] = p0_valid & stages[g].valid &
                         ((reg_a_live & (reg_a_ext == stages[g].dest)) |
                          (reg_b_live & (reg_b_ext == stages[g].dest)) |
                          (p0_uses_flags & stages[g].mod_flags));
    end
  endgenerate

  // The oldest stage hands a load over to the scoreboard only on a real advance.
  assign sb_set = advance & stages[DEPTH-1].valid & stages[DEPTH-1].is_load &
                  (stages[DEPTH-1].dest != MAX_REGISTER_BITS'(R0));

  slurm16_reg_scoreboard #(
    .REGISTER_BITS (REGISTER_BITS),
    .NUM_REGS      (NUM_REGS)
  ) u_sb (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .set     (sb_set),
    .set_reg (stages[DEPTH-1].dest[REGISTER_BITS-1:0]),
    .clr     (ld_done),
    .clr_reg (ld_done_reg),
    .look_a  (p0_regA),
    .look_b  (p0_regB),
    .look_c  (p0_dest),
    .hit_a   (hit_a),
    .hit_b   (hit_b),
    .hit_c   (hit_d)
  );

  assign hazard_sb = p0_valid & (hit_a | hit_b | hit_d);
  assign stall     = (|hazard) | hazard_sb;

endmodule

// File: doc/slurm16_cpu_scoreboard.md
# slurm16_cpu_scoreboard

Parametrised hazard and stall unit for the SLURM16 pipeline. It replaces purely combinational hazard comparison with internally tracked state: a DEPTH-stage shift register of in-flight destination and flag writers, plus a per-register scoreboard of outstanding multi-cycle loads. It sits beside the pipeline control and receives the already-decoded p0 (issue slot) fields. It drives per-stage hazard flags and a single stall request back to the pipeline.

## Interface
- REGISTER_BITS, 7: register index width; register 0 (R0) never hazards.
- DEPTH, 3: number of tracked pipeline stages after p0 (1..8).
- NUM_REGS, 2**REGISTER_BITS: scoreboard size.
- CLK  in  1  clock; all state changes on rising edge.
- RSTb  in  1  asynchronous, active-low reset.
- p0_valid  in  1  p0 holds a real instruction (not a bubble).
- p0_regA, p0_regB  in  REGISTER_BITS  source registers read by p0.
- p0_dest  in  REGISTER_BITS  register p0 writes (0 = none).
- p0_mod_flags  in  1  p0 writes flags.
- p0_uses_flags  in  1  p0 reads flags (conditional branch/mov).
- p0_is_load  in  1  p0 is a multi-cycle memory load.
- hold  in  1  external pipeline freeze; no state advances.
- flush  in  1  squash all tracked stage entries (branch taken, interrupt).
- ld_done  in  1  a load retired from memory this cycle.
- ld_done_reg  in  REGISTER_BITS  destination of the retiring load.
- hazard  out  DEPTH  bit i set: p0 depends on stage i+1.
- hazard_sb  out  1  p0 reads or writes a scoreboard-pending register.
- stall  out  1  p0 must not advance.

## Operation
- Stage entry: {valid, dest, mod_flags, is_load}. Stage 1 is youngest, DEPTH oldest.
- Advance occurs when hold=0. Stages shift 1→DEPTH. Stage 1 loads p0 fields with valid = p0_valid & ~stall; otherwise it receives a bubble (valid=0).
- hazard[i] is asserted when p0_valid and stage i+1 is valid and either:
  - (p0_regA≠0 and p0_regA==dest), or (p0_regB≠0 and p0_regB==dest); or
  - p0_uses_flags and the stage has mod_flags.
- Scoreboard: a bit per register.
  - Set for dest when stage DEPTH holds a valid is_load with dest≠0 and an advance occurs.
  - Cleared for ld_done_reg when ld_done=1.
  - Set and clear of the same register in the same cycle: set wins.
  - Bit 0 is forced to 0.
- hazard_sb = p0_valid & (sb[p0_regA] | sb[p0_regB] | sb[p0_dest]), with index 0 ignored. Checking p0_dest stalls WAW against an outstanding load.
- stall = |hazard | hazard_sb. It is combinational from the p0 inputs and registered state.
- Flush (with hold=0 or hold=1): all stage valid bits are cleared at the next edge, and stage 1 takes a bubble. The scoreboard is not touched; loads already issued to memory still retire.
- Flush has priority over advance. hold=1 without flush freezes stages and the scoreboard set path, but ld_done clears are still applied.
- ld_done for a register whose bit is already 0 is a no-op.

## Timing
- Reset (RSTb=0, asynchronous): all stage entries are invalid with zero fields, and the scoreboard is all zero. hazard=0, hazard_sb=0 and stall=0 follow combinationally.
- A reset asserted mid-operation discards all tracking immediately. Deassertion takes effect at the first CLK edge with RSTb=1.
- Hazard and stall have zero-cycle latency from the p0 inputs.
- A writer issued at edge n occupies stage 1 during cycle n+1 and stage k during cycle n+k (absent hold). It leaves tracking after edge n+DEPTH.
- A load's scoreboard bit is visible in the cycle after it leaves stage DEPTH. This gives continuous coverage with no gap.
- A load whose ld_done arrives at edge m no longer hazards from cycle m+1.

## Structure
- Package slurm16_hazard_pkg:
  - stage entry struct typedef;
  - R0 constant;
  - LINK_REGISTER constant, shared with the decoder.
- Sub-module slurm16_reg_scoreboard (NUM_REGS bits):
  - inputs: set/set_reg, clr/clr_reg, three lookup ports;
  - outputs: three hit bits.
- The top level holds the stage shift register and the comparators, built with a generate loop over DEPTH.

## Test plan
- Reset: drive p0_regA=5 with RSTb=0 → hazard=0, stall=0. Release reset and issue dest=5 → hazard=3'b001 next cycle when p0_regA=5.
- Distance: issue dest=4, then bubbles → p0_regB=4 gives hazard 001, 010, 100, then 000 on successive cycles. p0_regA=0 with a stage dest=0 → never a hazard.
- Flags: issue mod_flags=1, then p0_uses_flags=1 one cycle later → hazard[0]=1, stall=1. Stage 1 receives a bubble.
- Load scoreboard: load dest=7, DEPTH=3 → after 3 advances hazard_sb=1 for p0_regA=7 until ld_done_reg=7. The cycle after ld_done, stall=0.
- Simultaneous: ld_done_reg=9 on the same edge that a new load dest=9 exits stage DEPTH → the scoreboard bit stays 1.
- Flush/hold: with three valid writers, flush=1 → all hazard bits are 0 next cycle while scoreboard bits persist. hold=1 keeps hazard stable across 5 cycles.
